// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: register-file back end for an I2C slave front-end.
//
// Implements the usual register-device pointer protocol:
// - the first byte written after an address-write sets the register pointer;
// - later written bytes store into registers;
// - read bytes return registers.
// The pointer auto-increments after every data byte in either direction and
// persists across transactions. Read data is prefetched into i2c_data_tx one
// cycle after each prefetch start. stall is held for that cycle so the
// front-end never shifts a stale byte.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   i2c_addr_rw(_valid_stb) {addr[6:0], r/w} byte and its strobe (all addresses)
//   i2c_data_rx(_valid_stb) received data byte and its strobe
//   i2c_data_tx             byte the front-end loads for the next read
//   i2c_data_tx_loaded_stb  front-end copied i2c_data_tx into its shifter
//   i2c_data_tx_done_stb    8 TX bits shifted out (no action taken)
//   i2c_error_stb           protocol error, abandons the transaction
//   stall                   hold SCL low at the front-end's next stall point
//   status_in               live values for read-only slots, byte i = reg i
//   regs_out                RW register contents, read-only slots read 0
//   reg_wr_stb/idx/data     one-cycle notification of each accepted write
//   debug_state             current FSM state
module i2c_reg_bank #(
  parameter logic [6:0]          I2C_ADDRESS = 7'h42,
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         IDX_W       = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0] RO_MASK     = 16'hF000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i2c_addr_rw,
  input  logic                  i2c_addr_rw_valid_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  output logic [7:0]            i2c_data_tx,
  input  logic                  i2c_data_tx_loaded_stb,
  input  logic                  i2c_data_tx_done_stb,
  input  logic                  i2c_error_stb,
  output logic                  stall,
  input  logic [8*NUM_REGS-1:0] status_in,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  reg_wr_stb,
  output logic [IDX_W-1:0]      reg_wr_idx,
  output logic [7:0]            reg_wr_data,
  output logic [1:0]            debug_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWPtr  = 2'd1,
    StWData = 2'd2,
    StRData = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         tx_q;
  logic               pending_q;
  logic               wr_stb_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [7:0]         wr_data_q;
  logic               start_pf;
  logic               wr_en;
  logic [7:0]         pf_data;

  // Done strobe is observable only; nothing in the bank depends on it.
  logic unused_tx_done;
  assign unused_tx_done = i2c_data_tx_done_stb;

  // Next-state: error beats everything, then address bytes (this also covers
  // repeated start), then per-state data strobes.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    start_pf = 1'b0;
    wr_en    = 1'b0;
    if (i2c_error_stb) begin
      state_d = StIdle;
    end else if (i2c_addr_rw_valid_stb) begin
      if (i2c_addr_rw[7:1] != I2C_ADDRESS) begin
        state_d = StIdle;
      end else if (i2c_addr_rw[0]) begin
        state_d  = StRData;
        start_pf = 1'b1;
      end else begin
        state_d = StWPtr;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StWPtr: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_d    = i2c_data_rx[IDX_W-1:0];
            start_pf = 1'b1;
            state_d  = StWData;
          end
        end
        StWData: begin
          if (i2c_data_rx_valid_stb) begin
            // Read-only targets are still ACKed by the front-end; just skip the store.
            wr_en    = !RO_MASK[ptr_q];
            ptr_d    = ptr_q + IDX_W'(1);
            start_pf = 1'b1;
          end
        end
        StRData: begin
          if (i2c_data_tx_loaded_stb) begin
            ptr_d    = ptr_q + IDX_W'(1);
            start_pf = 1'b1;
          end
        end
      endcase
    end
  end

  // Prefetch reads the already-updated pointer one cycle after the start, so a
  // same-cycle write to the previous index can never alias the fetched slot.
  always_comb begin
    pf_data = RO_MASK[ptr_q] ? status_in[{ptr_q, 3'b000} +: 8] : regs_q[ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      tx_q      <= 8'h00;
      pending_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_stb_q <= wr_en;
      if (wr_en) begin
        regs_q[ptr_q] <= i2c_data_rx;
        wr_idx_q      <= ptr_q;
        wr_data_q     <= i2c_data_rx;
      end
      if (pending_q) begin
        tx_q <= pf_data;
      end
      pending_q <= start_pf;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[8*i +: 8] = RO_MASK[i] ? 8'h00 : regs_q[i];
    end
  end

  assign i2c_data_tx = tx_q;
  assign stall       = pending_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_idx  = wr_idx_q;
  assign reg_wr_data = wr_data_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: directed I2C byte sequences, with
// expected writes and read bytes queued by the stimulus and checked by a
// separate monitor whenever the DUT strobes a write or the front-end loads TX.
module tb_i2c_reg_bank;

  localparam int K_ADDR = 0;
  localparam int K_RX   = 1;
  localparam int K_LOAD = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   i2c_addr_rw = 8'h00;
  logic         i2c_addr_rw_valid_stb = 1'b0;
  logic [7:0]   i2c_data_rx = 8'h00;
  logic         i2c_data_rx_valid_stb = 1'b0;
  logic [7:0]   i2c_data_tx;
  logic         i2c_data_tx_loaded_stb = 1'b0;
  logic         i2c_data_tx_done_stb = 1'b0;
  logic         i2c_error_stb = 1'b0;
  logic         stall;
  logic [127:0] status_in = '0;
  logic [127:0] regs_out;
  logic         reg_wr_stb;
  logic [3:0]   reg_wr_idx;
  logic [7:0]   reg_wr_data;
  logic [1:0]   debug_state;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr [$];
  logic [7:0] exp_rd [$];
  logic [7:0] exp_regs [16];
  wr_t        mon_w;
  logic [7:0] mon_b;
  int         n_checks = 0;
  int         n_fail = 0;
  int         stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic       prev_strobe = 1'b0;

  i2c_reg_bank dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i2c_addr_rw            (i2c_addr_rw),
    .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
    .i2c_data_rx            (i2c_data_rx),
    .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
    .i2c_data_tx            (i2c_data_tx),
    .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
    .i2c_data_tx_done_stb   (i2c_data_tx_done_stb),
    .i2c_error_stb          (i2c_error_stb),
    .stall                  (stall),
    .status_in              (status_in),
    .regs_out               (regs_out),
    .reg_wr_stb             (reg_wr_stb),
    .reg_wr_idx             (reg_wr_idx),
    .reg_wr_data            (reg_wr_data),
    .debug_state            (debug_state)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] model_regs();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) begin
      v[8*i +: 8] = exp_regs[i];
    end
    return v;
  endfunction

  // One strobe cycle, then a quiet gap long enough for any prefetch to land.
  task automatic pulse(input int kind, input logic [7:0] b);
    @(posedge clk); #1;
    case (kind)
      K_ADDR: begin i2c_addr_rw = b; i2c_addr_rw_valid_stb = 1'b1; end
      K_RX:   begin i2c_data_rx = b; i2c_data_rx_valid_stb = 1'b1; end
      K_LOAD: i2c_data_tx_loaded_stb = 1'b1;
      K_DONE: i2c_data_tx_done_stb = 1'b1;
      default: i2c_error_stb = 1'b1;
    endcase
    @(posedge clk); #1;
    i2c_addr_rw_valid_stb  = 1'b0;
    i2c_data_rx_valid_stb  = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0;
    i2c_data_tx_done_stb   = 1'b0;
    i2c_error_stb          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [3:0] idx, input logic [7:0] b);
    wr_t w;
    w.idx = idx;
    w.data = b;
    exp_wr.push_back(w);
    exp_regs[idx] = b;
    pulse(K_RX, b);
  endtask

  task automatic read_byte(input logic [7:0] b);
    exp_rd.push_back(b);
    pulse(K_LOAD, 8'h00);
    pulse(K_DONE, 8'h00);
  endtask

  // Monitor: compares DUT output events against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reg_wr_stb) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got idx %0d data 0x%0h, expected no write",
                   reg_wr_idx, reg_wr_data);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_idx", 128'(reg_wr_idx), 128'(mon_w.idx));
          chk("wr_data", 128'(reg_wr_data), 128'(mon_w.data));
        end
      end
      if (i2c_data_tx_loaded_stb) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got 0x%0h, expected no load", i2c_data_tx);
        end else begin
          mon_b = exp_rd.pop_front();
          chk("read_byte", 128'(i2c_data_tx), 128'(mon_b));
        end
      end
      if (stall) begin
        stall_cnt++;
        chk("stall_after_strobe", 128'(prev_strobe), 128'd1);
        chk("stall_one_cycle", 128'(prev_stall), 128'd0);
      end
      prev_stall  = stall;
      prev_strobe = i2c_addr_rw_valid_stb | i2c_data_rx_valid_stb | i2c_data_tx_loaded_stb;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_regs_out", regs_out, 128'd0);
    chk("rst_tx", 128'(i2c_data_tx), 128'd0);
    chk("rst_stall", 128'(stall), 128'd0);
    chk("rst_wr_stb", 128'(reg_wr_stb), 128'd0);
    chk("rst_wr_idx", 128'(reg_wr_idx), 128'd0);
    chk("rst_wr_data", 128'(reg_wr_data), 128'd0);
    chk("rst_state", 128'(debug_state), 128'd0);

    // Pointer write then two data writes.
    pulse(K_ADDR, 8'h84);
    chk("state_w_ptr", 128'(debug_state), 128'd1);
    pulse(K_RX, 8'h03);
    chk("state_w_data", 128'(debug_state), 128'd2);
    write_byte(4'd3, 8'hA5);
    write_byte(4'd4, 8'h5A);
    chk("regs_after_write", regs_out, model_regs());
    // Read with no pointer write continues at pointer 5.
    pulse(K_ADDR, 8'h85);
    chk("state_r_data", 128'(debug_state), 128'd3);
    read_byte(8'h00);

    // Pointer 3, repeated start, read three bytes.
    pulse(K_ADDR, 8'h84);
    pulse(K_RX, 8'h03);
    stall_cnt = 0;
    pulse(K_ADDR, 8'h85);
    read_byte(8'hA5);
    read_byte(8'h5A);
    read_byte(8'h00);
    chk("stall_count_read", 128'(stall_cnt), 128'd4);

    // Read-only slot: write ignored, readback gives live status.
    status_in[14*8 +: 8] = 8'h77;
    status_in[15*8 +: 8] = 8'h5C;
    pulse(K_ADDR, 8'h84);
    pulse(K_RX, 8'h0E);
    pulse(K_RX, 8'h11);
    pulse(K_ADDR, 8'h84);
    pulse(K_RX, 8'h0E);
    pulse(K_ADDR, 8'h85);
    read_byte(8'h77);
    chk("regs_ro_masked", regs_out, model_regs());

    // Pointer wrap past the last (read-only) register.
    pulse(K_ADDR, 8'h84);
    pulse(K_RX, 8'h0F);
    pulse(K_RX, 8'hAA);
    write_byte(4'd0, 8'hBB);
    chk("regs_after_wrap", regs_out, model_regs());

    // Foreign address: data bytes ignored.
    pulse(K_ADDR, 8'h90);
    chk("state_foreign", 128'(debug_state), 128'd0);
    pulse(K_RX, 8'h01);
    pulse(K_RX, 8'h02);
    chk("state_foreign_after", 128'(debug_state), 128'd0);
    chk("regs_foreign", regs_out, model_regs());

    // Error mid-write aborts; following byte is ignored.
    pulse(K_ADDR, 8'h84);
    pulse(K_RX, 8'h05);
    pulse(K_ERR, 8'h00);
    chk("state_after_err", 128'(debug_state), 128'd0);
    pulse(K_RX, 8'h33);
    chk("regs_after_err", regs_out, model_regs());

    // Reset in the same cycle as a data byte: no write, everything cleared.
    pulse(K_ADDR, 8'h84);
    pulse(K_RX, 8'h07);
    @(posedge clk); #1;
    i2c_data_rx = 8'h44;
    i2c_data_rx_valid_stb = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    i2c_data_rx_valid_stb = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    chk("mid_rst_regs", regs_out, model_regs());
    chk("mid_rst_stall", 128'(stall), 128'd0);
    chk("mid_rst_state", 128'(debug_state), 128'd0);
    chk("mid_rst_tx", 128'(i2c_data_tx), 128'd0);
    repeat (3) @(negedge clk);

    // Pointer restarts at 0 after reset.
    pulse(K_ADDR, 8'h85);
    read_byte(8'h00);

    repeat (4) @(negedge clk);
    chk("exp_wr_drained", 128'(exp_wr.size()), 128'd0);
    chk("exp_rd_drained", 128'(exp_rd.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
